// File: rtl/uvmt_misc_st_dut_rsp_pkg.sv
// Shared types and default parameter values for the register-file responder.
`timescale 1ns/1ps
package uvmt_misc_st_dut_rsp_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_ADDR_WIDTH  = 4;
  localparam int unsigned DEF_NUM_REGS    = 12;
  localparam int unsigned DEF_RSP_LATENCY = 2;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;

  // Response payload is sized for the widest supported DATA_WIDTH; the top truncates.
  localparam int unsigned RSP_DATA_MAX = 64;

  typedef struct packed {
    logic [RSP_DATA_MAX-1:0] rdata;
    logic                    err;
  } rsp_t;

endpackage

// File: rtl/uvmt_misc_st_dut_rsp_fifo.sv
// Synchronous response FIFO, power-of-2 depth, payload type set by parameter.
`timescale 1ns/1ps
module uvmt_misc_st_dut_rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T             mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra MSB distinguishes full from empty; low bits wrap modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/uvmt_misc_st_dut_rsp.sv
// Register-file responder: valid/ready request port, fixed-latency pipeline,
// in-order response FIFO with credit-style backpressure on the request side.
`timescale 1ns/1ps
module uvmt_misc_st_dut_rsp
  import uvmt_misc_st_dut_rsp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_REGS    = DEF_NUM_REGS,
  parameter int unsigned RSP_LATENCY = DEF_RSP_LATENCY,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned NSTG  = RSP_LATENCY - 1;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]      outstanding;
  logic                  req_acc;
  logic                  rsp_acc;
  logic                  addr_ok;
  logic [DATA_WIDTH-1:0] rd_val;
  rsp_t                  acc_rsp;
  rsp_t                  push_rsp;
  rsp_t                  head_rsp;
  logic                  push_v;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign req_ready = !reset && (outstanding < CNT_W'(FIFO_DEPTH));
  assign req_acc   = req_valid && req_ready;
  assign rsp_valid = !fifo_empty;
  assign rsp_acc   = rsp_valid && rsp_ready;
  assign addr_ok   = 32'(req_addr) < NUM_REGS;

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_WIDTH'(i)) rd_val = regs[i];
    end
  end

  always_comb begin
    acc_rsp     = '0;
    acc_rsp.err = !addr_ok;
    if (!req_we) acc_rsp.rdata = RSP_DATA_MAX'(rd_val);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (req_acc && req_we) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (req_addr == ADDR_WIDTH'(i)) regs[i] <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else if (req_acc && !rsp_acc) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!req_acc && rsp_acc) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  // The FIFO write is the last latency stage, so only RSP_LATENCY-1 register
  // stages sit in front of it; the response is poppable RSP_LATENCY edges after accept.
  if (NSTG == 0) begin : g_direct
    assign push_v   = req_acc;
    assign push_rsp = acc_rsp;
  end else begin : g_pipe
    logic [NSTG-1:0] stg_v;
    rsp_t            stg_rsp [NSTG];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stg_v <= '0;
        for (int unsigned i = 0; i < NSTG; i++) stg_rsp[i] <= '0;
      end else begin
        stg_v[0]   <= req_acc;
        stg_rsp[0] <= acc_rsp;
        for (int unsigned i = 1; i < NSTG; i++) begin
          stg_v[i]   <= stg_v[i-1];
          stg_rsp[i] <= stg_rsp[i-1];
        end
      end
    end

    assign push_v   = stg_v[NSTG-1];
    assign push_rsp = stg_rsp[NSTG-1];
  end

  uvmt_misc_st_dut_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (rsp_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_v),
    .din   (push_rsp),
    .pop   (rsp_acc),
    .dout  (head_rsp),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rsp_err   = rsp_valid && head_rsp.err;
  assign rsp_rdata = rsp_valid ? DATA_WIDTH'(head_rsp.rdata) : '0;

  a_outstanding_bound: assert property (
    @(posedge clk) disable iff (reset) outstanding <= CNT_W'(FIFO_DEPTH));
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (reset) !(push_v && fifo_full));

endmodule

// File: tb/tb_uvmt_misc_st_dut_rsp.sv
// Bench for uvmt_misc_st_dut_rsp: vector table, directed corner sequences and
// random traffic, all checked cycle by cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_uvmt_misc_st_dut_rsp;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 4;
  localparam int NUM_REGS    = 12;
  localparam int RSP_LATENCY = 2;
  localparam int FIFO_DEPTH  = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic                  req_we = 1'b0;
  logic [ADDR_WIDTH-1:0] req_addr = '0;
  logic [DATA_WIDTH-1:0] req_wdata = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  uvmt_misc_st_dut_rsp #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .RSP_LATENCY (RSP_LATENCY),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned elig;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t        q[$];
  logic [31:0] mregs [16];
  vec_t        tbl [13];
  int unsigned cyc;
  int          total = 0;
  int          bad = 0;
  logic        dut_acc, dut_pop, s_err;
  logic [31:0] s_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
  endtask

  // One clock: drive inputs, compare outputs with the model, advance both.
  task automatic tick(input logic v, input logic we, input logic [3:0] a,
                      input logic [31:0] d, input logic rr);
    exp_t e;
    logic ev, er;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
    #1;
    er = (q.size() < FIFO_DEPTH);
    ev = (q.size() > 0) && (q[0].elig <= cyc + 1);
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    chk("rsp_rdata", 64'(rsp_rdata), ev ? 64'(q[0].rdata) : 64'(0));
    chk("rsp_err",   64'(rsp_err),   64'(ev && q[0].err));
    dut_acc = v && req_ready;
    dut_pop = rsp_valid && rr;
    s_rdata = rsp_rdata;
    s_err   = rsp_err;
    if (ev && rr) void'(q.pop_front());
    if (v && er) begin
      e.err   = (32'(a) >= NUM_REGS);
      e.rdata = (we || e.err) ? 32'h0 : mregs[a];
      e.elig  = cyc + 1 + RSP_LATENCY;
      q.push_back(e);
      if (we && !e.err) mregs[a] = d;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
  endtask

  task automatic do_reset();
    req_valid = 1'b0; rsp_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_err",   64'(rsp_err),   64'(0));
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'(1));
  endtask

  task automatic do_vec(input int idx);
    int unsigned acc_c;
    bit got;
    acc_c = 0;
    got = 0;
    for (int w = 0; w < 10 && !got; w++) begin
      tick(1'b1, tbl[idx].we, tbl[idx].addr, tbl[idx].wdata, 1'b1);
      if (dut_acc) begin got = 1; acc_c = cyc; end
    end
    if (!got) begin
      chk("vec_accept_timeout", 64'(0), 64'(1));
      return;
    end
    got = 0;
    for (int w = 0; w < 20 && !got; w++) begin
      tick(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
      if (dut_pop) begin
        got = 1;
        chk("vec_latency", 64'(cyc - acc_c), 64'(RSP_LATENCY));
        chk("vec_rdata",   64'(s_rdata),     64'(tbl[idx].exp_rdata));
        chk("vec_err",     64'(s_err),       64'(tbl[idx].exp_err));
      end
    end
    if (!got) chk("vec_rsp_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, n_pop;
    cyc = 0;
    model_clear();

    tbl[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 4'd3,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 4'd13, 32'h0,        32'h0,        1'b1};
    tbl[3]  = '{1'b0, 4'd13, 32'h0,        32'h0,        1'b1};
    tbl[4]  = '{1'b1, 4'd13, 32'hCAFEF00D, 32'h0,        1'b1};
    tbl[5]  = '{1'b0, 4'd12, 32'h0,        32'h0,        1'b1};
    tbl[6]  = '{1'b1, 4'd11, 32'h12345678, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 4'd11, 32'h0,        32'h12345678, 1'b0};
    tbl[8]  = '{1'b0, 4'd0,  32'h0,        32'h0,        1'b0};
    tbl[9]  = '{1'b1, 4'd0,  32'hA5A5A5A5, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 4'd0,  32'h0,        32'hA5A5A5A5, 1'b0};
    tbl[11] = '{1'b0, 4'd3,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[12] = '{1'b0, 4'd15, 32'h0,        32'h0,        1'b1};

    #1;
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 13; i++) do_vec(i);

    // Write then read same address back to back: ordered responses, latency 2.
    do_reset();
    tick(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b1);
    tick(1'b1, 1'b0, 4'd3, 32'h0,        1'b1);
    tick(1'b0, 1'b0, 4'd0, 32'h0,        1'b1);
    chk("b2b_first_pop", 64'(dut_pop), 64'(1));
    chk("b2b_first_data", 64'(s_rdata), 64'(0));
    tick(1'b0, 1'b0, 4'd0, 32'h0,        1'b1);
    chk("b2b_second_pop", 64'(dut_pop), 64'(1));
    chk("b2b_second_data", 64'(s_rdata), 64'(32'hDEADBEEF));
    idle(3);

    // Backpressure: six reads with rsp_ready low, only FIFO_DEPTH get in.
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, 4'(i), 32'h0, 1'b0);
      if (dut_acc) n_acc++;
    end
    chk("bp_accepts", 64'(n_acc), 64'(FIFO_DEPTH));
    tick(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    chk("bp_first_pop", 64'(dut_pop), 64'(1));
    #0;
    chk("bp_ready_after_pop", 64'(req_ready), 64'(1));
    n_pop = 1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
      if (dut_pop) n_pop++;
    end
    chk("bp_pops", 64'(n_pop), 64'(FIFO_DEPTH));

    // Streaming: one accept and one response per cycle, steady occupancy.
    n_acc = 0; n_pop = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), $urandom, 1'b1);
      if (dut_acc) n_acc++;
      if (dut_pop) n_pop++;
    end
    chk("stream_accepts", 64'(n_acc), 64'(20));
    chk("stream_pops", 64'(n_pop), 64'(20 - RSP_LATENCY));
    chk("stream_outstanding", 64'(dut.outstanding), 64'(RSP_LATENCY));
    idle(6);

    // Reset with transactions in flight.
    tick(1'b1, 1'b1, 4'd0, 32'h55AA55AA, 1'b1);
    idle(4);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 4'd0, 32'h0, 1'b0);
    do_reset();
    n_pop = 0;
    tick(1'b1, 1'b0, 4'd0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
      if (dut_pop) begin
        n_pop++;
        chk("rst_read0_data", 64'(s_rdata), 64'(0));
      end
    end
    chk("rst_single_rsp", 64'(n_pop), 64'(1));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 3) != 0));
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
